// File: rtl/data_memory_bus.sv
// ---------------------------------------------------------------------------
// data_memory_bus
// Data-side memory responder for the single-cycle processor. Serves word
// accesses to a data RAM and to a small peripheral page containing a
// free-running cycle counter and a byte output FIFO that drains through a
// valid/ready port.
//
// Address map (word address = direction[31:2]):
//   0x000 .. 4*DEPTH-1 : RAM
//   0x1000             : CYCLE      (read counter / write loads counter)
//   0x1004             : FIFO_DATA  (write pushes write_data[7:0], reads 0)
//   0x1008             : STATUS     {level[7:4], 0, overflow, empty, full}
//                                   write bit 3 = 1 clears overflow
//   other              : reads 0, writes ignored
//
// Ports:
//   clk         in   1   clock, all state updates on rising edge
//   reset       in   1   asynchronous active-high reset of peripheral state
//   direction   in  32   byte address, bits [1:0] ignored
//   write_data  in  32   store data
//   mem_write   in   1   store strobe
//   read_data   out 32   combinational load data
//   out_data    out  8   FIFO head byte
//   out_valid   out  1   FIFO not empty
//   out_ready   in   1   sink accepts head byte
// ---------------------------------------------------------------------------
module data_memory_bus #(
   parameter int DEPTH      = 64,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] direction,
   input  logic [31:0] write_data,
   input  logic        mem_write,
   output logic [31:0] read_data,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready
);

   localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = PTR_W + 1;

   localparam logic [29:0] WA_CYCLE  = 30'h400;
   localparam logic [29:0] WA_FIFO   = 30'h401;
   localparam logic [29:0] WA_STATUS = 30'h402;

   logic [31:0] r_mem [DEPTH];
   logic [7:0]  r_fifo [FIFO_DEPTH];
   logic [31:0] r_cycle;
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [LVL_W-1:0] r_level;
   logic        r_overflow;

   logic [29:0] w_word;
   logic        w_is_ram;
   logic        w_wr_en;
   logic        w_cycle_wr;
   logic        w_status_wr;
   logic        w_push_req;
   logic        w_push_ok;
   logic        w_pop;
   logic        w_full;
   logic        w_empty;
   logic [3:0]  w_level4;
   logic [31:0] w_status;
   logic        w_unused;

   assign w_word   = direction[31:2];
   assign w_unused = ^direction[1:0];
   assign w_is_ram = (w_word < 30'(DEPTH));

   // Stores are blocked while reset is held so RAM cannot be corrupted by
   // a processor running through reset.
   assign w_wr_en     = mem_write && !reset;
   assign w_cycle_wr  = w_wr_en && (w_word == WA_CYCLE);
   assign w_status_wr = w_wr_en && (w_word == WA_STATUS);
   assign w_push_req  = w_wr_en && (w_word == WA_FIFO);

   assign w_full   = (r_level == LVL_W'(FIFO_DEPTH));
   assign w_empty  = (r_level == '0);
   assign w_pop    = out_valid && out_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign w_push_ok = w_push_req && (!w_full || w_pop);

   assign out_valid = !w_empty;
   assign out_data  = r_fifo[r_rptr];

   assign w_level4 = 4'(r_level);
   assign w_status = {24'h0, w_level4, 1'b0, r_overflow, w_empty, w_full};

   always_comb begin
      read_data = 32'h0;
      if (w_is_ram) begin
         read_data = r_mem[w_word[RAM_AW-1:0]];
      end else if (w_word == WA_CYCLE) begin
         read_data = r_cycle;
      end else if (w_word == WA_STATUS) begin
         read_data = w_status;
      end
   end

   // RAM contents survive reset.
   always_ff @(posedge clk) begin
      if (w_wr_en && w_is_ram) begin
         r_mem[w_word[RAM_AW-1:0]] <= write_data;
      end
   end

   // FIFO storage needs no reset: entries are only visible when level != 0.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_fifo[r_wptr] <= write_data[7:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cycle    <= 32'h0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_cycle_wr) begin
            r_cycle <= write_data;
         end else begin
            r_cycle <= r_cycle + 32'd1;
         end

         if (w_push_ok) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end

         if (w_push_ok && !w_pop) begin
            r_level <= r_level + 1'b1;
         end else if (!w_push_ok && w_pop) begin
            r_level <= r_level - 1'b1;
         end

         if (w_push_req && !w_push_ok) begin
            r_overflow <= 1'b1;
         end else if (w_status_wr && write_data[3]) begin
            r_overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_data_memory_bus.sv
module tb_data_memory_bus;

   logic        clk;
   logic        reset;
   logic [31:0] direction;
   logic [31:0] write_data;
   logic        mem_write;
   logic [31:0] read_data;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;

   int n_tests;
   int n_fail;

   localparam logic [31:0] A_CYCLE  = 32'h1000;
   localparam logic [31:0] A_FIFO   = 32'h1004;
   localparam logic [31:0] A_STATUS = 32'h1008;

   data_memory_bus #(.DEPTH(64), .FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .direction  (direction),
      .write_data (write_data),
      .mem_write  (mem_write),
      .read_data  (read_data),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge; checks happen 1 time unit later.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      direction  = addr;
      write_data = data;
      mem_write  = 1'b1;
      @(negedge clk);
      mem_write  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      direction = A_STATUS;
      #1;
      n_tests++;
      if (read_data !== 32'h2) begin
         n_fail++;
         $display("FAIL reset_status got=%h exp=%h", read_data, 32'h2);
      end
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_valid got=%b exp=0", out_valid);
      end
   endtask

   task automatic test_counter();
      logic [31:0] exp_a [3];
      direction = A_CYCLE;
      for (int i = 0; i < 3; i++) begin
         if (i != 0) @(negedge clk);
         #1;
         n_tests++;
         if (read_data !== 32'(i)) begin
            n_fail++;
            $display("FAIL cycle_after_reset[%0d] got=%h exp=%h", i, read_data, 32'(i));
         end
      end
      exp_a[0] = 32'hFFFF_FFFE;
      exp_a[1] = 32'hFFFF_FFFF;
      exp_a[2] = 32'h0000_0000;
      do_write(A_CYCLE, 32'hFFFF_FFFE);
      for (int i = 0; i < 3; i++) begin
         if (i != 0) @(negedge clk);
         #1;
         n_tests++;
         if (read_data !== exp_a[i]) begin
            n_fail++;
            $display("FAIL cycle_wrap[%0d] got=%h exp=%h", i, read_data, exp_a[i]);
         end
      end
   endtask

   task automatic test_ram();
      do_write(32'h10, 32'hE594_4010);
      do_write(32'h14, 32'hE084_1009);
      do_write(32'h100, 32'hDEAD_BEEF);
      direction = 32'h10;
      #1;
      n_tests++;
      if (read_data !== 32'hE594_4010) begin
         n_fail++;
         $display("FAIL ram_0x10 got=%h exp=%h", read_data, 32'hE594_4010);
      end
      direction = 32'h13;
      #1;
      n_tests++;
      if (read_data !== 32'hE594_4010) begin
         n_fail++;
         $display("FAIL ram_0x13 got=%h exp=%h", read_data, 32'hE594_4010);
      end
      direction = 32'h14;
      #1;
      n_tests++;
      if (read_data !== 32'hE084_1009) begin
         n_fail++;
         $display("FAIL ram_0x14 got=%h exp=%h", read_data, 32'hE084_1009);
      end
      direction = 32'h100;
      #1;
      n_tests++;
      if (read_data !== 32'h0) begin
         n_fail++;
         $display("FAIL ram_out_of_range got=%h exp=%h", read_data, 32'h0);
      end
      direction = 32'h2000;
      #1;
      n_tests++;
      if (read_data !== 32'h0) begin
         n_fail++;
         $display("FAIL unmapped_read got=%h exp=%h", read_data, 32'h0);
      end
      // Store attempted during reset must be ignored; RAM must survive reset.
      @(negedge clk);
      reset      = 1'b1;
      direction  = 32'h10;
      write_data = 32'h1234_5678;
      mem_write  = 1'b1;
      @(negedge clk);
      mem_write  = 1'b0;
      reset      = 1'b0;
      #1;
      n_tests++;
      if (read_data !== 32'hE594_4010) begin
         n_fail++;
         $display("FAIL ram_after_reset got=%h exp=%h", read_data, 32'hE594_4010);
      end
   endtask

   task automatic test_fifo_fill();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) do_write(A_FIFO, 32'hFFFF_FF41 + 32'(i));
      direction = A_STATUS;
      #1;
      n_tests++;
      if (read_data !== 32'h41) begin
         n_fail++;
         $display("FAIL fifo_full_status got=%h exp=%h", read_data, 32'h41);
      end
      do_write(A_FIFO, 32'h45);
      direction = A_STATUS;
      #1;
      n_tests++;
      if (read_data !== 32'h45) begin
         n_fail++;
         $display("FAIL fifo_overflow_status got=%h exp=%h", read_data, 32'h45);
      end
      n_tests++;
      if (out_data !== 8'h41) begin
         n_fail++;
         $display("FAIL fifo_head_after_drop got=%h exp=%h", out_data, 8'h41);
      end
      direction = A_FIFO;
      #1;
      n_tests++;
      if (read_data !== 32'h0) begin
         n_fail++;
         $display("FAIL fifo_data_read got=%h exp=%h", read_data, 32'h0);
      end
      do_write(A_STATUS, 32'h8);
      direction = A_STATUS;
      #1;
      n_tests++;
      if (read_data !== 32'h41) begin
         n_fail++;
         $display("FAIL overflow_clear got=%h exp=%h", read_data, 32'h41);
      end
   endtask

   task automatic test_fifo_drain();
      logic [7:0] exp_b;
      @(negedge clk);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i != 0) @(negedge clk);
         exp_b = 8'h41 + 8'(i);
         #1;
         n_tests++;
         if (out_valid !== 1'b1 || out_data !== exp_b) begin
            n_fail++;
            $display("FAIL drain[%0d] got=%h/%b exp=%h/1", i, out_data, out_valid, exp_b);
         end
         // Hold stability: head must not change between edges.
         #2;
         n_tests++;
         if (out_data !== exp_b) begin
            n_fail++;
            $display("FAIL drain_hold[%0d] got=%h exp=%h", i, out_data, exp_b);
         end
      end
      @(negedge clk);
      out_ready = 1'b0;
      direction = A_STATUS;
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || read_data !== 32'h2) begin
         n_fail++;
         $display("FAIL drained got=%h/%b exp=%h/0", read_data, out_valid, 32'h2);
      end
      do_write(A_FIFO, 32'h55);
      #1;
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 8'h55) begin
         n_fail++;
         $display("FAIL wrap_push got=%h/%b exp=%h/1", out_data, out_valid, 8'h55);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_pop got=%b exp=0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_c [4];
      for (int i = 0; i < 4; i++) do_write(A_FIFO, 32'h61 + 32'(i));
      // Push and pop together while full.
      direction  = A_FIFO;
      write_data = 32'h66;
      mem_write  = 1'b1;
      out_ready  = 1'b1;
      #1;
      n_tests++;
      if (out_data !== 8'h61) begin
         n_fail++;
         $display("FAIL simul_head got=%h exp=%h", out_data, 8'h61);
      end
      @(negedge clk);
      mem_write = 1'b0;
      out_ready = 1'b0;
      direction = A_STATUS;
      #1;
      n_tests++;
      if (read_data !== 32'h41) begin
         n_fail++;
         $display("FAIL simul_status got=%h exp=%h", read_data, 32'h41);
      end
      exp_c[0] = 8'h62;
      exp_c[1] = 8'h63;
      exp_c[2] = 8'h64;
      exp_c[3] = 8'h66;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i != 0) @(negedge clk);
         #1;
         n_tests++;
         if (out_data !== exp_c[i]) begin
            n_fail++;
            $display("FAIL simul_seq[%0d] got=%h exp=%h", i, out_data, exp_c[i]);
         end
      end
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL simul_empty got=%b exp=0", out_valid);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) do_write(A_FIFO, 32'h70 + 32'(i));
      direction = A_STATUS;
      #1;
      n_tests++;
      if (read_data !== 32'h30) begin
         n_fail++;
         $display("FAIL pre_reset_status got=%h exp=%h", read_data, 32'h30);
      end
      // Assert reset 2 units after the falling edge, well before the next rise.
      #1;
      reset = 1'b1;
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || read_data !== 32'h2) begin
         n_fail++;
         $display("FAIL async_reset got=%h/%b exp=%h/0", read_data, out_valid, 32'h2);
      end
      direction = A_CYCLE;
      #1;
      n_tests++;
      if (read_data !== 32'h0) begin
         n_fail++;
         $display("FAIL async_reset_cycle got=%h exp=%h", read_data, 32'h0);
      end
      @(negedge clk);
      reset = 1'b0;
      direction = 32'h14;
      #1;
      n_tests++;
      if (read_data !== 32'hE084_1009) begin
         n_fail++;
         $display("FAIL ram_after_mid_reset got=%h exp=%h", read_data, 32'hE084_1009);
      end
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      reset      = 1'b1;
      direction  = 32'h0;
      write_data = 32'h0;
      mem_write  = 1'b0;
      out_ready  = 1'b0;
      test_reset();
      test_counter();
      test_ram();
      test_fifo_fill();
      test_fifo_drain();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
